// File: rtl/irq_pending_dispatch.sv
// irq_pending_dispatch: edge-captured pending requests, masked into an external priority encoder, dispatched over valid/ready
module irq_pending_dispatch #(
    parameter int N    = 32,
    parameter int IDXW = 5,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    input  logic            clr_all,
    output logic [N-1:0]    enc_i,
    input  logic [IDXW-1:0] enc_out,
    input  logic            enc_gs,
    output logic            irq_valid,
    output logic [IDXW-1:0] irq_id,
    input  logic            irq_ready,
    output logic [N-1:0]    pending_o,
    output logic [CNTW-1:0] drop_cnt
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t          r_state;
    logic [N-1:0]    r_req_q;
    logic [N-1:0]    r_pending;
    logic            r_irq_valid;
    logic [IDXW-1:0] r_irq_id;
    logic [CNTW-1:0] r_drop_cnt;

    logic [N-1:0]    w_edge;
    logic            w_accept;
    logic [N-1:0]    w_acc_vec;
    logic [N-1:0]    w_clr_vec;
    logic [N-1:0]    w_pending_nxt;
    logic            w_drop;

    assign w_edge        = req_i & ~r_req_q;
    assign w_accept      = r_irq_valid & irq_ready;
    assign w_clr_vec     = clr_all ? '1 : w_acc_vec;
    assign w_pending_nxt = w_edge | (r_pending & ~w_clr_vec);
    assign w_drop        = |(w_edge & r_pending & ~w_clr_vec);

    assign enc_i     = r_pending & ~mask_i;
    assign irq_valid = r_irq_valid;
    assign irq_id    = r_irq_id;
    assign pending_o = r_pending;
    assign drop_cnt  = r_drop_cnt;

    // One-hot clear vector for the line the consumer is accepting this cycle
    always_comb begin
        w_acc_vec           = '0;
        w_acc_vec[r_irq_id] = w_accept;
    end

    // Request history for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_req_q <= '0;
        else     r_req_q <= req_i;
    end

    // Pending bits: new edges always set, accept or clr_all clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_pending_nxt;
    end

    // Saturating count of edges that landed on a line still pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    // Dispatcher: sample the encoder in IDLE, hold a frozen offer until accept or clr_all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_irq_valid <= 1'b0;
            r_irq_id    <= '0;
        end else begin
            case (r_state)
                IDLE: if (enc_gs && !clr_all) begin
                    r_irq_id    <= enc_out;
                    r_irq_valid <= 1'b1;
                    r_state     <= OFFER;
                end
                OFFER: if (clr_all || irq_ready) begin
                    r_irq_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_pending_dispatch.sv
// tb_irq_pending_dispatch: directed checks of capture, priority dispatch, masking, drops and aborts
module tb_irq_pending_dispatch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_i;
    logic [31:0] mask_i;
    logic        clr_all;
    logic [31:0] enc_i;
    logic [4:0]  enc_out;
    logic        enc_gs;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_ready;
    logic [31:0] pending_o;
    logic [7:0]  drop_cnt;
    int checks = 0;
    int failures = 0;

    irq_pending_dispatch dut (
        .clk(clk), .rst(rst), .req_i(req_i), .mask_i(mask_i), .clr_all(clr_all),
        .enc_i(enc_i), .enc_out(enc_out), .enc_gs(enc_gs),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
        .pending_o(pending_o), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference priority encoder: highest set bit wins
    always_comb begin
        enc_gs  = |enc_i;
        enc_out = '0;
        for (int k = 0; k < 32; k++)
            if (enc_i[k]) enc_out = 5'(k);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_i = '0; mask_i = '0; clr_all = 1'b0; irq_ready = 1'b0;
        cyc(1);
        chk("rst_valid", irq_valid, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_pend", pending_o, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        // 1: single request, latency
        req_i = 32'h20;
        cyc(1);
        chk("t1_pend", pending_o, 32'h20);
        chk("t1_enc", enc_i, 32'h20);
        chk("t1_valid0", irq_valid, 0);
        req_i = '0;
        cyc(1);
        chk("t1_valid", irq_valid, 1);
        chk("t1_id", irq_id, 5);
        irq_ready = 1'b1;
        cyc(1);
        chk("t1_clr", pending_o, 0);
        chk("t1_idle", irq_valid, 0);
        // 2: three simultaneous edges, ready held
        req_i = 32'h8002_0008;
        cyc(1);
        req_i = '0;
        cyc(1);
        chk("t2_id31", irq_id, 31);
        chk("t2_v31", irq_valid, 1);
        cyc(1);
        chk("t2_gap1", irq_valid, 0);
        cyc(1);
        chk("t2_id17", irq_id, 17);
        chk("t2_v17", irq_valid, 1);
        cyc(1);
        chk("t2_gap2", irq_valid, 0);
        cyc(1);
        chk("t2_id3", irq_id, 3);
        chk("t2_v3", irq_valid, 1);
        cyc(1);
        chk("t2_end", irq_valid, 0);
        chk("t2_pend", pending_o, 0);
        cyc(1);
        chk("t2_stay", irq_valid, 0);
        // 3: masking
        mask_i = 32'h8000_0000;
        req_i = 32'h8000_0004;
        cyc(1);
        req_i = '0;
        cyc(1);
        chk("t3_id2", irq_id, 2);
        chk("t3_v2", irq_valid, 1);
        cyc(1);
        chk("t3_pend", pending_o, 32'h8000_0000);
        chk("t3_enc", enc_i, 0);
        cyc(1);
        chk("t3_hidden", irq_valid, 0);
        mask_i = '0;
        cyc(1);
        chk("t3_id31", irq_id, 31);
        chk("t3_v31", irq_valid, 1);
        cyc(1);
        chk("t3_pend0", pending_o, 0);
        irq_ready = 1'b0;
        // 4: offer stability while stalled
        req_i = 32'h10;
        cyc(1);
        req_i = '0;
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) req_i = 32'h4000_0000;
            if (i == 3) req_i = '0;
            if (i == 5) mask_i = 32'h10;
            cyc(1);
            chk("t4_hold_v", irq_valid, 1);
            chk("t4_hold_id", irq_id, 4);
        end
        mask_i = '0;
        irq_ready = 1'b1;
        cyc(1);
        chk("t4_acc", irq_valid, 0);
        chk("t4_pend", pending_o, 32'h4000_0000);
        cyc(1);
        chk("t4_id30", irq_id, 30);
        chk("t4_v30", irq_valid, 1);
        cyc(1);
        chk("t4_pend0", pending_o, 0);
        irq_ready = 1'b0;
        // 5: drops, edge in accept cycle, saturation
        req_i = 32'h200;
        cyc(1);
        req_i = '0;
        cyc(1);
        chk("t5_id9", irq_id, 9);
        req_i = 32'h200;
        cyc(1);
        chk("t5_drop1", drop_cnt, 1);
        req_i = '0;
        cyc(1);
        req_i = 32'h200;
        irq_ready = 1'b1;
        cyc(1);
        chk("t5_acc_v", irq_valid, 0);
        chk("t5_keep", pending_o, 32'h200);
        chk("t5_nodrop", drop_cnt, 1);
        req_i = '0;
        irq_ready = 1'b0;
        cyc(1);
        chk("t5_reoffer_v", irq_valid, 1);
        chk("t5_reoffer_id", irq_id, 9);
        for (int i = 0; i < 300; i++) begin
            req_i = 32'h200;
            cyc(1);
            req_i = '0;
            cyc(1);
        end
        chk("t5_sat", drop_cnt, 255);
        // 6: clr_all abort and async reset
        req_i = 32'h1000;
        cyc(1);
        req_i = '0;
        chk("t6_pre", pending_o, 32'h1200);
        clr_all = 1'b1;
        cyc(1);
        chk("t6_clr_v", irq_valid, 0);
        chk("t6_clr_p", pending_o, 0);
        clr_all = 1'b0;
        cyc(1);
        chk("t6_idle", irq_valid, 0);
        req_i = 32'h80;
        cyc(1);
        req_i = '0;
        cyc(1);
        chk("t6_id7", irq_id, 7);
        chk("t6_v7", irq_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_v", irq_valid, 0);
        chk("t6_arst_id", irq_id, 0);
        chk("t6_arst_d", drop_cnt, 0);
        chk("t6_arst_p", pending_o, 0);
        cyc(1);
        rst = 1'b0;
        cyc(2);
        chk("t6_after", irq_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
